mem_wb_stage: RTL and testbench



---
 rtl/cpu_pkg.sv | 23 ++
 rtl/mem_wb_data_memory.sv | 35 +++
 rtl/mem_wb_stage.sv | 100 ++++++++++
 tb/tb_mem_wb_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared pipeline definitions: datapath widths and the execute-stage output bundle.
package cpu_pkg;

  localparam int DATA_WIDTH     = 16;
  localparam int REG_ADDR_WIDTH = 4;
  localparam int MEM_ADDR_WIDTH = 4;

  // Execute-stage output fields, shared by the execute stage and mem_wb_stage.
  typedef struct packed {
    logic [DATA_WIDTH-1:0]     result;
    logic [REG_ADDR_WIDTH-1:0] reg_addr;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      write_enable;
    logic                      load_enable;
    logic                      store_enable;
  } ex_mem_bundle_t;

  // A store never writes the register file, even if write_enable rides along.
  function automatic logic writes_reg(input ex_mem_bundle_t b);
    return b.write_enable & ~b.store_enable;
  endfunction

endpackage

// File: rtl/mem_wb_data_memory.sv
// Data memory: synchronous read-before-write port, combinational debug read,
// synchronous clear on reset.
module data_memory #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear on reset; otherwise write and read the same address, read sees the old word.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (wr_en) mem[addr] <= wdata;
      if (rd_en) rdata <= mem[addr];
    end
  end

  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// Memory + writeback stages: captures the execute bundle into M, performs the
// memory access, and drives the register-file write port from W one edge later.
module mem_wb_stage
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH     = cpu_pkg::DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = cpu_pkg::REG_ADDR_WIDTH,
  parameter int MEM_ADDR_WIDTH = cpu_pkg::MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [DATA_WIDTH-1:0]     result,
  input  logic [REG_ADDR_WIDTH-1:0] reg_addr,
  input  logic                      write_enable,
  input  logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                      store_enable,
  input  logic                      load_enable,
  output logic [DATA_WIDTH-1:0]     wb_data,
  output logic [REG_ADDR_WIDTH-1:0] wb_reg_addr,
  output logic                      wb_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] m_reg_addr,
  output logic                      m_write_enable,
  output logic [DATA_WIDTH-1:0]     m_result,
  output logic                      m_is_load,
  input  logic [MEM_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data
);

  ex_mem_bundle_t        ex_in;
  ex_mem_bundle_t        m_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] w_data;
  logic [REG_ADDR_WIDTH-1:0] w_reg_addr;
  logic                  w_write_enable;

  // Pack the incoming execute fields into the shared bundle layout.
  always_comb begin
    ex_in              = '0;
    ex_in.result       = result;
    ex_in.reg_addr     = reg_addr;
    ex_in.mem_addr     = mem_addr;
    ex_in.write_enable = write_enable;
    ex_in.load_enable  = load_enable;
    ex_in.store_enable = store_enable;
  end

  // Flush suppresses both the memory side effects and the M enables.
  data_memory #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(MEM_ADDR_WIDTH)
  ) u_dmem (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (store_enable & ~flush),
    .rd_en    (load_enable & ~flush),
    .addr     (mem_addr),
    .wdata    (result),
    .rdata    (mem_q),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  // M stage: capture the bundle; flush keeps the data fields but kills all enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_q <= '0;
    end else begin
      m_q <= ex_in;
      if (flush) begin
        m_q.write_enable <= 1'b0;
        m_q.load_enable  <= 1'b0;
        m_q.store_enable <= 1'b0;
      end
    end
  end

  // W stage: select load data or ALU result; always advances from M, even on flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      w_data         <= '0;
      w_reg_addr     <= '0;
      w_write_enable <= 1'b0;
    end else begin
      w_data         <= m_q.load_enable ? mem_q : m_q.result;
      w_reg_addr     <= m_q.reg_addr;
      w_write_enable <= writes_reg(m_q);
    end
  end

  assign wb_data         = w_data;
  assign wb_reg_addr     = w_reg_addr;
  assign wb_write_enable = w_write_enable;

  assign m_reg_addr      = m_q.reg_addr;
  assign m_write_enable  = m_q.write_enable;
  assign m_result        = m_q.result;
  assign m_is_load       = m_q.load_enable;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed-vector bench for mem_wb_stage with hand-computed expectations.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic [15:0] result;
  logic [3:0]  reg_addr, mem_addr, dbg_addr;
  logic        write_enable, store_enable, load_enable;
  logic [15:0] wb_data, m_result, dbg_data;
  logic [3:0]  wb_reg_addr, m_reg_addr;
  logic        wb_write_enable, m_write_enable, m_is_load;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .flush(flush),
    .result(result), .reg_addr(reg_addr), .write_enable(write_enable),
    .mem_addr(mem_addr), .store_enable(store_enable), .load_enable(load_enable),
    .wb_data(wb_data), .wb_reg_addr(wb_reg_addr), .wb_write_enable(wb_write_enable),
    .m_reg_addr(m_reg_addr), .m_write_enable(m_write_enable), .m_result(m_result),
    .m_is_load(m_is_load), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] res, input logic [3:0] ra, input logic we,
                       input logic [3:0] ma, input logic st, input logic ld);
    result = res; reg_addr = ra; write_enable = we;
    mem_addr = ma; store_enable = st; load_enable = ld;
  endtask

  task automatic idle();
    drive(16'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic dbg_chk(input string tag, input logic [3:0] a, input logic [15:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  task automatic wb_chk(input string tag, input logic [15:0] d, input logic [3:0] ra, input logic we);
    chk({tag, ".data"}, {16'h0, wb_data}, {16'h0, d});
    chk({tag, ".addr"}, {28'h0, wb_reg_addr}, {28'h0, ra});
    chk({tag, ".we"},   {31'h0, wb_write_enable}, {31'h0, we});
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; dbg_addr = '0;
    idle();
    tick(); tick();
    wb_chk("rst", 16'h0, 4'h0, 1'b0);
    chk("rst.m_we",   {31'h0, m_write_enable}, 32'h0);
    chk("rst.m_load", {31'h0, m_is_load}, 32'h0);
    dbg_chk("rst.dbg0", 4'h0, 16'h0);
    reset = 1'b0;

    // ADD writeback
    drive(16'h0008, 4'h1, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    chk("add.m_reg",    {28'h0, m_reg_addr}, 32'h1);
    chk("add.m_we",     {31'h0, m_write_enable}, 32'h1);
    chk("add.m_result", {16'h0, m_result}, 32'h8);
    chk("add.m_load",   {31'h0, m_is_load}, 32'h0);
    idle();
    tick();
    wb_chk("add.wb", 16'h0008, 4'h1, 1'b1);

    // Store (write_enable set, must be gated) then back-to-back load of same address
    drive(16'h000F, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0);
    tick();
    dbg_chk("st.dbg1", 4'h1, 16'h000F);
    drive(16'h0000, 4'h3, 1'b1, 4'h1, 1'b0, 1'b1);
    tick();
    chk("st.wb_we", {31'h0, wb_write_enable}, 32'h0);
    chk("ld.m_load", {31'h0, m_is_load}, 32'h1);
    chk("ld.m_reg",  {28'h0, m_reg_addr}, 32'h3);
    idle();
    tick();
    wb_chk("ld.wb", 16'h000F, 4'h3, 1'b1);

    // Flush kills a store and its enables
    drive(16'h00AA, 4'h5, 1'b1, 4'h2, 1'b1, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    idle();
    dbg_chk("fl.dbg2", 4'h2, 16'h0);
    chk("fl.m_we", {31'h0, m_write_enable}, 32'h0);
    tick();
    chk("fl.wb_we", {31'h0, wb_write_enable}, 32'h0);

    // Load+store same cycle: store wins in memory, mem_q gets old word, no register write
    drive(16'h0007, 4'h0, 1'b0, 4'h4, 1'b1, 1'b0);
    tick();
    drive(16'h0009, 4'h5, 1'b1, 4'h4, 1'b1, 1'b1);
    tick();
    dbg_chk("ldst.dbg4", 4'h4, 16'h0009);
    idle();
    tick();
    wb_chk("ldst.wb", 16'h0007, 4'h5, 1'b0);

    // Load without write_enable: read happens, nothing written back
    drive(16'h0000, 4'h6, 1'b0, 4'h4, 1'b0, 1'b1);
    tick();
    idle();
    tick();
    wb_chk("ldnw.wb", 16'h0009, 4'h6, 1'b0);

    // Address wrap at top of memory, then back-to-back ADDs at full throughput
    drive(16'hBEEF, 4'h0, 1'b0, 4'hF, 1'b1, 1'b0);
    tick();
    dbg_chk("top.dbgF", 4'hF, 16'hBEEF);
    drive(16'h0011, 4'h8, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    drive(16'h0022, 4'h9, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    chk("tp.m_result", {16'h0, m_result}, 32'h22);
    wb_chk("tp.wb1", 16'h0011, 4'h8, 1'b1);
    idle();
    tick();
    wb_chk("tp.wb2", 16'h0022, 4'h9, 1'b1);

    // Reset mid-stream with an ADD in M and a store presented at the reset edge
    drive(16'h1234, 4'h2, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    drive(16'h000F, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    wb_chk("mrst.wb", 16'h0, 4'h0, 1'b0);
    chk("mrst.m_we",     {31'h0, m_write_enable}, 32'h0);
    chk("mrst.m_load",   {31'h0, m_is_load}, 32'h0);
    chk("mrst.m_reg",    {28'h0, m_reg_addr}, 32'h0);
    chk("mrst.m_result", {16'h0, m_result}, 32'h0);
    dbg_chk("mrst.dbg1", 4'h1, 16'h0);
    dbg_chk("mrst.dbg4", 4'h4, 16'h0);
    dbg_chk("mrst.dbgF", 4'hF, 16'h0);

    // Resume after reset
    drive(16'h0003, 4'h7, 1'b1, 4'h0, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    wb_chk("resume.wb", 16'h0003, 4'h7, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
